// File: rtl/instr_fetch.sv
// instr_fetch: RV32I instruction-fetch stage. Owns the PC, fetches words over a
// req/ack handshake, and fills the IF/ID register for decode. It honours decode
// back-pressure and execute redirects. A redirect that lands while a fetch is
// still in flight lets that fetch complete and then discards its data.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect halts fetching and pulses fetch_misaligned.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        IFID_valid,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic [31:0] drop_addr;
  logic        req_q;
  logic        halted;

  logic        slot_free;
  logic        accept;
  logic        pending;
  logic        misaligned;
  logic [31:0] target;

  assign slot_free = !IFID_valid || !id_stall;
  assign accept    = imem_req && imem_ack;
  assign pending   = imem_req && !imem_ack;

  // The request is registered so that a stall arriving mid-cycle cannot
  // retract it. The reset gate makes the request drop at once while reset is
  // held, and lets it rise in the first cycle after release.
  assign imem_req  = rst_n && req_q;
  assign imem_addr = (state == S_DROP) ? drop_addr : {pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign misaligned = |redirect_pc[1:0];

  // One-cycle trap pulse for each misaligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_misaligned <= 1'b0;
    else        fetch_misaligned <= redirect_valid && misaligned;
  end
`else
  assign target     = redirect_pc & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  // Fetch FSM: PC, request, hold buffer and the IF/ID register. Redirect wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      req_q      <= 1'b1;
      halted     <= 1'b0;
      IFID_valid <= 1'b0;
      IFID_instr <= 32'h0000_0013;
      IFID_pc    <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      drop_addr  <= '0;
    end else if (redirect_valid) begin
      IFID_valid <= 1'b0;
      pc         <= target;
      halted     <= misaligned;
      if (pending) begin
        // The in-flight fetch must stay on the bus until acked, so its address is frozen here.
        state     <= S_DROP;
        drop_addr <= imem_addr;
        req_q     <= 1'b1;
      end else begin
        state <= S_FETCH;
        req_q <= !misaligned;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (accept) begin
            pc <= imem_addr + 32'd4;
            if (slot_free) begin
              IFID_valid <= 1'b1;
              IFID_instr <= imem_rdata;
              IFID_pc    <= imem_addr;
              req_q      <= 1'b1;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= imem_addr;
              state      <= S_HOLD;
              req_q      <= 1'b0;
            end
          end else begin
            if (slot_free) IFID_valid <= 1'b0;
            req_q <= pending || (slot_free && !halted);
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            IFID_valid <= 1'b1;
            IFID_instr <= hold_instr;
            IFID_pc    <= hold_pc;
            state      <= S_FETCH;
            req_q      <= !halted;
          end
        end
        S_DROP: begin
          if (accept) begin
            state <= S_FETCH;
            req_q <= !halted;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the RV32I pipeline, directly upstream of control decode. Owns the program counter, issues word fetches to instruction memory over a request/acknowledge handshake, and holds the fetched word and its PC in the IF/ID pipeline register that decode reads. Honours decode back-pressure (`id_stall`) and branch/jump redirects from execute, discarding any wrong-path fetch still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` input 1: single clock; everything updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address; word-aligned.
- `imem_ack` input 1: memory accepted and returned data; sampled on edges where `imem_req`=1.
- `imem_rdata` input 32: instruction word, valid when `imem_ack`=1.
- `redirect_valid` input 1: execute requests a PC change.
- `redirect_pc` input 32: new PC.
- `id_stall` input 1: decode cannot accept a new IF/ID entry.
- `IFID_valid` output 1: the IF/ID register holds a live instruction.
- `IFID_instr` output 32: instruction to decode.
- `IFID_pc` output 32: PC of `IFID_instr`.
- `fetch_misaligned` output 1: present only with FETCH_MISALIGN_TRAP_EN; see Configuration.

## Operation
- Internal state: `pc` (next fetch address), a one-entry hold buffer (`hold_instr`, `hold_pc`), and an FSM.
- FSM states:
  - S_FETCH: issuing and receiving fetches.
  - S_HOLD: a word arrived while IF/ID was full and stalled; it sits in the hold buffer; `imem_req`=0.
  - S_DROP: a redirect arrived while a request was outstanding; wait for its ack, then discard the data.
- Slot free = `!IFID_valid || !id_stall`.
- In S_FETCH, `imem_req`=1 when the slot is free or a request is outstanding. `imem_addr`=`pc`.
- Outstanding = `imem_req` was 1 on the previous edge without `imem_ack`.
- Once raised, `imem_req` and `imem_addr` hold stable until acked, regardless of stall or redirect.
- Ack in S_FETCH with slot free:
  - IF/ID loads {1, `imem_rdata`, `imem_addr`}.
  - `pc` increments by 4, wrapping modulo 2^32.
- Ack in S_FETCH with slot not free: hold buffer loads the data, `pc` += 4, go to S_HOLD.
- S_HOLD with `!id_stall`: IF/ID loads from the hold buffer, go to S_FETCH. A new request can be issued on the following cycle.
- Slot free and no ack: `IFID_valid` clears to 0, creating a bubble.
- Redirect has highest priority. On any edge with `redirect_valid`=1:
  - `IFID_valid` goes to 0 and the hold buffer is invalidated.
  - `pc` loads `redirect_pc`.
  - If a request is outstanding and not acked on this edge, go to S_DROP; otherwise go to S_FETCH.
- Ack on the same edge as the redirect: the data is discarded.
- S_DROP: `imem_req` stays 1 with the old address until ack. The ack data is discarded, then go to S_FETCH.
- A second redirect while in S_DROP overwrites `pc`; the last redirect wins.

## Timing
- Reset (async assert) values:
  - `pc`=`RESET_PC`, FSM=S_FETCH.
  - `IFID_valid`=0, `IFID_instr`=32'h0000_0013 (NOP), `IFID_pc`=0.
  - `imem_req`=0 while `rst_n`=0; `fetch_misaligned`=0.
- First cycle after `rst_n` rises: `imem_req`=1 with `imem_addr`=`RESET_PC`.
- Zero-wait memory (ack in the same cycle as req):
  - Instruction is visible on IF/ID one cycle after the request.
  - Throughput is one instruction per cycle.
- Redirect-to-fetch latency:
  - Without an outstanding request, `imem_addr`=`redirect_pc` on the cycle after the redirect.
  - From S_DROP, `imem_addr`=`redirect_pc` on the cycle after the dropped ack.
- `id_stall` with `IFID_valid`=1 freezes `IFID_instr` and `IFID_pc` exactly.
- Reset asserted mid-request aborts immediately. Memory must tolerate the dropped request.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 does not fetch.
  - `fetch_misaligned` pulses 1 for one cycle and IF/ID stays invalid.
  - `pc` holds `redirect_pc`, and fetching stays halted until the next aligned redirect.
- Undefined:
  - The `fetch_misaligned` port is absent.
  - `redirect_pc[1:0]` is ignored (forced to 0).

## Test plan
- Reset, `RESET_PC`=32'h100, zero-wait memory returning addr^32'hA5A5_0000 -> `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles; `IFID_pc` follows one cycle later with `IFID_valid`=1.
- `id_stall` held 3 cycles while an ack lands -> word captured in S_HOLD, `imem_req`=0, `IFID_instr` frozen; on release, held word appears next cycle with its correct PC and no word is lost or duplicated.
- Memory with 3-cycle ack latency, redirect to 0x200 on the second wait cycle -> `imem_addr` stays on the old address until ack; that data is discarded; next request addr=0x200; `IFID_valid`=0 throughout.
- Redirect coincident with ack and `id_stall`=1 -> `IFID_valid`=0 next cycle, hold buffer empty, next fetch at `redirect_pc`.
- PC at 32'hFFFF_FFFC -> next fetch address 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x302 -> one-cycle `fetch_misaligned` pulse, no `imem_req`; a later redirect to 0x300 resumes fetching. Without the macro, the same redirect fetches 0x300.
